// File: rtl/from_local_xy.sv
// Local injection port for a 2-D mesh router: steers core packets by signed dx/dy
// into four first-word-fall-through direction FIFOs and counts packets addressed to (0,0).
module from_local_xy #(
   parameter int PACKET_WIDTH   = 30,
   parameter int BUFFER_DEPTH   = 4,
   parameter int DX_MSB         = 29,
   parameter int DX_LSB         = 21,
   parameter int DY_MSB         = 20,
   parameter int DY_LSB         = 12,
   parameter int DROP_CNT_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [PACKET_WIDTH-1:0]   din,
   input  logic                      din_wen,
   output logic                      din_ready,
   input  logic                      ren_e,
   input  logic                      ren_w,
   input  logic                      ren_n,
   input  logic                      ren_s,
   output logic [PACKET_WIDTH-1:0]   dout_e,
   output logic [PACKET_WIDTH-1:0]   dout_w,
   output logic [PACKET_WIDTH-1:0]   dout_n,
   output logic [PACKET_WIDTH-1:0]   dout_s,
   output logic                      empty_e,
   output logic                      empty_w,
   output logic                      empty_n,
   output logic                      empty_s,
   output logic                      full_e,
   output logic                      full_w,
   output logic                      full_n,
   output logic                      full_s,
   output logic [DROP_CNT_WIDTH-1:0] drop_count,
   output logic                      drop_err
);

   localparam int DXW = DX_MSB - DX_LSB + 1;
   localparam int DYW = DY_MSB - DY_LSB + 1;
   localparam int AW  = $clog2(BUFFER_DEPTH);

   localparam logic [AW:0]               CNT_ONE  = 1;
   localparam logic [AW:0]               CNT_FULL = (AW + 1)'(BUFFER_DEPTH);
   localparam logic [AW-1:0]             PTR_ONE  = 1;
   localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE = 1;

   // Low two bits of the E/W/N/S codes index the per-direction vectors below.
   typedef enum logic [2:0] {DIR_E = 3'd0, DIR_W = 3'd1, DIR_N = 3'd2, DIR_S = 3'd3,
                             DIR_DROP = 3'd4} dir_e;

   logic [DXW-1:0]          dx;
   logic [DYW-1:0]          dy;
   dir_e                    sel;
   logic [3:0]              ren_v;
   logic [3:0]              push_v;
   logic [3:0]              empty_v;
   logic [3:0]              full_v;
   logic [PACKET_WIDTH-1:0] dout_v [4];
   logic                    drop_acc;

   assign dx    = din[DX_MSB:DX_LSB];
   assign dy    = din[DY_MSB:DY_LSB];
   assign ren_v = {ren_s, ren_n, ren_w, ren_e};

   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      sel = DIR_DROP;
      if (dx != '0)      sel = dx[DXW-1] ? DIR_W : DIR_E;
      else if (dy != '0) sel = dy[DYW-1] ? DIR_S : DIR_N;
   end

   // Ready depends only on din and registered full flags, never on ren_*.
   always_comb begin
      din_ready = 1'b1;
      push_v    = '0;
      if (sel != DIR_DROP) begin
         din_ready = !full_v[sel[1:0]];
         if (din_wen && din_ready) push_v[sel[1:0]] = 1'b1;
      end
   end

   assign drop_acc = din_wen && (sel == DIR_DROP);

   for (genvar i = 0; i < 4; i++) begin : g_fifo
      logic [PACKET_WIDTH-1:0] mem [BUFFER_DEPTH];
      logic [AW-1:0]           wr_ptr;
      logic [AW-1:0]           rd_ptr;
      logic [AW:0]             count;
      logic [AW:0]             count_nxt;
      logic                    empty_q;
      logic                    full_q;
      logic                    pop;

      // Pop uses the registered empty flag, so a push into an empty FIFO ignores ren.
      assign pop = ren_v[i] && !empty_q;

      always_comb begin
         count_nxt = count;
         if (push_v[i] && !pop)      count_nxt = count + CNT_ONE;
         else if (!push_v[i] && pop) count_nxt = count - CNT_ONE;
      end

      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      always_ff @(posedge clk) begin
         if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
         end else begin
            if (push_v[i]) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)       rd_ptr <= rd_ptr + PTR_ONE;
            count   <= count_nxt;
            empty_q <= (count_nxt == '0);
            full_q  <= (count_nxt == CNT_FULL);
         end
      end

      // NOTE: storage is not reset; dout is forced to 0 while empty instead.
      always_ff @(posedge clk) begin
         if (push_v[i]) mem[wr_ptr] <= din;
      end

      assign empty_v[i] = empty_q;
      assign full_v[i]  = full_q;
      assign dout_v[i]  = empty_q ? '0 : mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_count <= '0;
         drop_err   <= 1'b0;
      end else if (drop_acc) begin
         if (drop_count != '1) drop_count <= drop_count + DROP_ONE;
         drop_err <= 1'b1;
      end
   end

   assign dout_e  = dout_v[0];
   assign dout_w  = dout_v[1];
   assign dout_n  = dout_v[2];
   assign dout_s  = dout_v[3];
   assign empty_e = empty_v[0];
   assign empty_w = empty_v[1];
   assign empty_n = empty_v[2];
   assign empty_s = empty_v[3];
   assign full_e  = full_v[0];
   assign full_w  = full_v[1];
   assign full_n  = full_v[2];
   assign full_s  = full_v[3];

endmodule
